rheed_result_arbiter: RTL

Collects the per-crop CNN parameter results (one 40-bit word per crop per frame) and merges them round-robin onto a single tagged AXI-Stream toward the host DMA path. Sits downstream of the per-crop CNN instances inside the RHEED inference top level. Sequences each frame: it opens collection on frame_start, marks tlast on the final crop's word, and pulses frame_done.

---
 rtl/rheed_pkg.sv | 20 ++
 rtl/rheed_result_arbiter_rr_grant.sv | 36 +++
 rtl/rheed_result_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rheed_pkg.sv
// Shared constants and types for the RHEED result arbiter.
package rheed_pkg;

    localparam int RESULT_W    = 40;
    localparam int CROP_IDX_W  = 8;
    localparam int FRAME_CNT_W = 16;
    localparam int OUT_W       = 64;

    // Output word layout: {frame_cnt, crop_idx, result}
    localparam int RESULT_LSB  = 0;
    localparam int CROP_LSB    = 40;
    localparam int FRAME_LSB   = 48;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/rheed_result_arbiter_rr_grant.sv
// Combinational round-robin picker: lowest requester at or above ptr,
// otherwise lowest requester overall (wrap-around).
module rr_grant #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;

    // Masked priority search; descending loops leave the lowest set index
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        req_hi = req & hi_mask;
        any    = |req;
        idx    = '0;
        gnt    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i]) idx = IDX_W'(i);
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/rheed_result_arbiter.sv
// Merges one result word per crop per frame onto a tagged AXI-Stream.
// Frame sequencing: IDLE -> COLLECT (round-robin accept) -> DRAIN (wait tlast).
module rheed_result_arbiter #(
    parameter int NUM_CROPS      = 5,
    parameter int RESULT_W       = rheed_pkg::RESULT_W,
    parameter int FRAME_CNT_W    = rheed_pkg::FRAME_CNT_W,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                frame_start,
    input  logic [NUM_CROPS-1:0]                s_axis_tvalid,
    output logic [NUM_CROPS-1:0]                s_axis_tready,
    input  logic [NUM_CROPS-1:0][RESULT_W-1:0]  s_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [rheed_pkg::OUT_W-1:0]         m_axis_tdata,
    output logic                                m_axis_tlast,
    output logic                                frame_done,
    output logic                                busy,
    output logic [NUM_CROPS-1:0]                served_mask,
    output logic                                err_overrun,
    output logic                                err_timeout,
    input  logic                                err_clear
);

    import rheed_pkg::*;

    localparam int IDX_W = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [NUM_CROPS-1:0]    served_q, served_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic                    tvalid_q, tvalid_d;
    logic [OUT_W-1:0]        tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_overrun_q, err_overrun_d;
    logic                    err_timeout_q, err_timeout_d;

    logic                    out_free;
    logic [NUM_CROPS-1:0]    req;
    logic [NUM_CROPS-1:0]    gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    accept;
    logic                    last_word;
    logic [OUT_W-1:0]        out_word;

    // Eligibility: collecting, output slot free, valid and not yet served
    always_comb begin
        out_free = !tvalid_q || m_axis_tready;
        req      = '0;
        if (state_q == COLLECT && out_free) req = s_axis_tvalid & ~served_q;
    end

    rr_grant #(.N(NUM_CROPS), .IDX_W(IDX_W)) u_grant (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (accept)
    );

    // Build the tagged output word for the granted crop
    always_comb begin
        out_word = '0;
        out_word[FRAME_LSB  +: FRAME_CNT_W] = frame_cnt_q;
        out_word[CROP_LSB   +: CROP_IDX_W]  = CROP_IDX_W'(gnt_idx);
        out_word[RESULT_LSB +: RESULT_W]    = s_axis_tdata[gnt_idx];
        last_word = &(served_q | gnt);
    end

    // Next-state: frame FSM, output register, watchdog and sticky errors
    always_comb begin
        state_d       = state_q;
        served_d      = served_q;
        rr_ptr_d      = rr_ptr_q;
        frame_cnt_d   = frame_cnt_q;
        wdog_d        = wdog_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        frame_done_d  = 1'b0;
        err_overrun_d = err_overrun_q & ~err_clear;
        err_timeout_d = err_timeout_q & ~err_clear;

        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

        if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = out_word;
            tlast_d  = last_word;
            served_d = served_q | gnt;
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_CROPS - 1)) ? '0 : gnt_idx + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = COLLECT;
                    served_d = '0;
                    rr_ptr_d = '0;
                    wdog_d   = '0;
                end
            end
            COLLECT: begin
                if (frame_start) err_overrun_d = 1'b1;
                if (accept) begin
                    wdog_d = '0;
                    if (last_word) state_d = DRAIN;
                end else if (wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) err_timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                // Still busy this cycle, so a coincident frame_start is an overrun
                if (frame_start) err_overrun_d = 1'b1;
                wdog_d = '0;
                if (tvalid_q && m_axis_tready && tlast_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any pending output word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            served_q      <= '0;
            rr_ptr_q      <= '0;
            frame_cnt_q   <= '0;
            wdog_q        <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            served_q      <= served_d;
            rr_ptr_q      <= rr_ptr_d;
            frame_cnt_q   <= frame_cnt_d;
            wdog_q        <= wdog_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            frame_done_q  <= frame_done_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign s_axis_tready = gnt;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != IDLE);
    assign served_mask   = served_q;
    assign err_overrun   = err_overrun_q;
    assign err_timeout   = err_timeout_q;

endmodule
